// File: rtl/actor_sync_buffer_pkg.sv
// Shared actor definitions: default widths, drain FSM encoding and the
// width of the optional commit timestamp (ACTOR_BUF_TIMESTAMP_EN).
package actor_sync_buffer_pkg;

    localparam int ACTOR_ID_WIDTH_DEF = 4;
    localparam int DATA_WIDTH_DEF     = 32;
    localparam int STAMP_WIDTH        = 32;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } buf_state_t;

endpackage

// File: rtl/actor_prio_enc.sv
// Combinational lowest-set-bit priority encoder: returns the index of the
// lowest set request bit and whether any bit is set.
module actor_prio_enc #(
    parameter int N  = 16,
    parameter int IW = 4
) (
    input  logic [N-1:0]  req,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        any = |req;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = IW'(i);
        end
    end

endmodule

// File: rtl/actor_sync_buffer.sv
// Double-banked actor output buffer. CGRA writes land in a shadow bank; a
// sync strobe commits the dirty entries atomically into the active bank,
// which is then drained one word per valid/ready handshake.
// Optional build macro: ACTOR_BUF_TIMESTAMP_EN adds a free-running cycle
// counter, captured at each commit and presented on OUT_STAMP_O.
//
//  state    | meaning
//  ST_IDLE  | nothing to drain; a sync commits immediately
//  ST_DRAIN | presenting lowest dirty active entry; a sync is held as pending
module actor_sync_buffer
    import actor_sync_buffer_pkg::*;
#(
    parameter int ACTOR_ID_WIDTH = ACTOR_ID_WIDTH_DEF,
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int NUM_ACTORS     = 16
) (
    input  logic                      CLK_I,
    input  logic                      RST_N_I,
    input  logic                      ACTOR_WR_ENABLE_I,
    input  logic [ACTOR_ID_WIDTH-1:0] ACTOR_WR_ADDR_I,
    input  logic [DATA_WIDTH-1:0]     ACTOR_DATA_I,
    input  logic                      ACTOR_SYNC_OUT_I,
    output logic                      OUT_VALID_O,
    input  logic                      OUT_READY_I,
    output logic [ACTOR_ID_WIDTH-1:0] OUT_ADDR_O,
    output logic [DATA_WIDTH-1:0]     OUT_DATA_O,
`ifdef ACTOR_BUF_TIMESTAMP_EN
    output logic [STAMP_WIDTH-1:0]    OUT_STAMP_O,
`endif
    output logic                      BUSY_O,
    output logic                      OVERRUN_O,
    output logic                      ADDR_ERR_O
);

    buf_state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0]     shadow_data [NUM_ACTORS];
    logic [DATA_WIDTH-1:0]     active_data [NUM_ACTORS];
    logic [NUM_ACTORS-1:0]     shadow_dirty, active_mask;
    logic                      pending, pending_nxt;
    logic                      overrun, addr_err, overrun_set;
    logic [ACTOR_ID_WIDTH-1:0] out_addr;
    logic [DATA_WIDTH-1:0]     out_data;

    logic                      wr_valid, wr_bad, hs, commit, step;
    logic [NUM_ACTORS-1:0]     wr_mask, commit_mask, step_mask, enc_req;
    logic [ACTOR_ID_WIDTH-1:0] enc_idx;
    logic                      enc_any;
    logic [DATA_WIDTH-1:0]     commit_word;

    assign wr_valid = ACTOR_WR_ENABLE_I &&
                      ({1'b0, ACTOR_WR_ADDR_I} < (ACTOR_ID_WIDTH + 1)'(NUM_ACTORS));
    assign wr_bad   = ACTOR_WR_ENABLE_I && !wr_valid;
    assign wr_mask  = wr_valid ? (NUM_ACTORS'(1) << ACTOR_WR_ADDR_I) : '0;

    // A write in the commit cycle is folded into that commit.
    assign commit_mask = shadow_dirty | wr_mask;
    assign step_mask   = active_mask & ~(NUM_ACTORS'(1) << out_addr);
    assign hs          = (state == ST_DRAIN) && OUT_READY_I;
    assign enc_req     = commit ? commit_mask : step_mask;

    actor_prio_enc #(
        .N  (NUM_ACTORS),
        .IW (ACTOR_ID_WIDTH)
    ) u_prio_enc (
        .req (enc_req),
        .idx (enc_idx),
        .any (enc_any)
    );

    assign commit_word = (wr_valid && (ACTOR_WR_ADDR_I == enc_idx)) ? ACTOR_DATA_I
                                                                      : shadow_data[enc_idx];

    // State register.
    always_ff @(posedge CLK_I) begin
        if (!RST_N_I) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Next state, commit/step decisions and pending/overrun tracking.
    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        commit      = 1'b0;
        step        = 1'b0;
        overrun_set = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ACTOR_SYNC_OUT_I) commit = 1'b1;
            end
            ST_DRAIN: begin
                if (hs && (step_mask == '0)) begin
                    // Drain done: a held or simultaneous sync commits now.
                    if (pending || ACTOR_SYNC_OUT_I) commit = 1'b1;
                    overrun_set = pending && ACTOR_SYNC_OUT_I;
                    pending_nxt = 1'b0;
                    state_nxt   = ST_IDLE;
                end else begin
                    step = hs;
                    if (ACTOR_SYNC_OUT_I) begin
                        if (pending) overrun_set = 1'b1;
                        else         pending_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (commit) begin
            pending_nxt = 1'b0;
            state_nxt   = (commit_mask != '0) ? ST_DRAIN : ST_IDLE;
        end
    end

    // Masks, flags and registered drain outputs.
    always_ff @(posedge CLK_I) begin
        if (!RST_N_I) begin
            shadow_dirty <= '0;
            active_mask  <= '0;
            pending      <= 1'b0;
            overrun      <= 1'b0;
            addr_err     <= 1'b0;
            out_addr     <= '0;
            out_data     <= '0;
        end else begin
            pending <= pending_nxt;
            if (overrun_set) overrun  <= 1'b1;
            if (wr_bad)      addr_err <= 1'b1;
            if (commit) begin
                shadow_dirty <= '0;
                active_mask  <= commit_mask;
            end else begin
                shadow_dirty <= shadow_dirty | wr_mask;
                if (hs) active_mask <= step_mask;
            end
            if (commit || step) begin
                out_addr <= enc_idx;
                out_data <= commit ? commit_word : active_data[enc_idx];
            end
        end
    end

    // Data banks are never cleared; only the dirty masks qualify them.
    always_ff @(posedge CLK_I) begin
        if (RST_N_I) begin
            if (wr_valid) shadow_data[ACTOR_WR_ADDR_I] <= ACTOR_DATA_I;
            if (commit) begin
                for (int i = 0; i < NUM_ACTORS; i++) begin
                    active_data[i] <= (wr_valid && (int'(ACTOR_WR_ADDR_I) == i))
                                      ? ACTOR_DATA_I : shadow_data[i];
                end
            end
        end
    end

`ifdef ACTOR_BUF_TIMESTAMP_EN
    logic [STAMP_WIDTH-1:0] cycle_cnt, stamp;

    // Free-running cycle counter, sampled at every commit.
    always_ff @(posedge CLK_I) begin
        if (!RST_N_I) begin
            cycle_cnt <= '0;
            stamp     <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
            if (commit) stamp <= cycle_cnt;
        end
    end

    assign OUT_STAMP_O = stamp;
`endif

    assign OUT_VALID_O = (state == ST_DRAIN);
    assign OUT_ADDR_O  = out_addr;
    assign OUT_DATA_O  = out_data;
    assign BUSY_O      = (state == ST_DRAIN) || pending;
    assign OVERRUN_O   = overrun;
    assign ADDR_ERR_O  = addr_err;

endmodule

// File: tb/tb_actor_sync_buffer.sv
// Bench for actor_sync_buffer: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level model built from queues.
module tb_actor_sync_buffer;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NA = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          sync = 1'b0;
    logic          ready = 1'b0;
    logic          out_valid, busy, overrun, addr_err;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;

    actor_sync_buffer #(
        .ACTOR_ID_WIDTH (AW),
        .DATA_WIDTH     (DW),
        .NUM_ACTORS     (NA)
    ) dut (
        .CLK_I             (clk),
        .RST_N_I           (rst_n),
        .ACTOR_WR_ENABLE_I (wr_en),
        .ACTOR_WR_ADDR_I   (wr_addr),
        .ACTOR_DATA_I      (wr_data),
        .ACTOR_SYNC_OUT_I  (sync),
        .OUT_VALID_O       (out_valid),
        .OUT_READY_I       (ready),
        .OUT_ADDR_O        (out_addr),
        .OUT_DATA_O        (out_data),
        .BUSY_O            (busy),
        .OVERRUN_O         (overrun),
        .ADDR_ERR_O        (addr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          a;
        logic [31:0] d;
    } word_t;

    // Reference model state.
    word_t       q[$];
    logic [31:0] sh [NA];
    bit          dirty [NA];
    bit          pend, ov, aerr, m_rst, chk_on;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic m_commit();
        for (int i = 0; i < NA; i++) begin
            if (dirty[i]) begin
                q.push_back('{a: i, d: sh[i]});
                dirty[i] = 0;
            end
        end
    endtask

    // One clock: compare outputs against the model, then apply the next
    // inputs and advance the model across the coming rising edge.
    task automatic cycle(input logic r, input logic en, input int addr,
                         input logic [31:0] d, input logic s, input logic rd);
        @(negedge clk);
        if (chk_on) begin
            chk("valid", 64'(out_valid), 64'(q.size() > 0));
            chk("busy", 64'(busy), 64'((q.size() > 0) || pend));
            chk("overrun", 64'(overrun), 64'(ov));
            chk("addr_err", 64'(addr_err), 64'(aerr));
            if (q.size() > 0) begin
                chk("out_addr", 64'(out_addr), 64'(q[0].a));
                chk("out_data", 64'(out_data), 64'(q[0].d));
            end
            if (m_rst) begin
                chk("rst_addr", 64'(out_addr), 64'd0);
                chk("rst_data", 64'(out_data), 64'd0);
            end
        end
        rst_n   = r;
        wr_en   = en;
        wr_addr = AW'(addr);
        wr_data = d;
        sync    = s;
        ready   = rd;
        if (!r) begin
            q.delete();
            for (int i = 0; i < NA; i++) dirty[i] = 0;
            pend  = 0;
            ov    = 0;
            aerr  = 0;
            m_rst = 1;
        end else begin
            m_rst = 0;
            if (en) begin
                if (addr < NA) begin
                    sh[addr]    = d;
                    dirty[addr] = 1;
                end else begin
                    aerr = 1;
                end
            end
            if (q.size() == 0) begin
                if (s) m_commit();
            end else begin
                if (rd) void'(q.pop_front());
                if (q.size() == 0) begin
                    if (pend && s) ov = 1;
                    if (pend || s) m_commit();
                    pend = 0;
                end else if (s) begin
                    if (pend) ov = 1;
                    else      pend = 1;
                end
            end
        end
    endtask

    task automatic idle(input int n, input logic rd);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, rd);
    endtask

    task automatic wr(input int addr, input logic [31:0] d);
        cycle(1, 1, addr, d, 0, 1);
    endtask

    initial begin
        chk_on = 0;
        pend = 0; ov = 0; aerr = 0; m_rst = 0;
        for (int i = 0; i < NA; i++) begin
            dirty[i] = 0;
            sh[i]    = '0;
        end
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        chk_on = 1;
        idle(2, 1);

        // Last write wins; drained lowest address first.
        wr(3, 32'hA);
        wr(1, 32'hB);
        wr(3, 32'hC);
        cycle(1, 0, 0, 0, 1, 1);
        idle(4, 1);

        // Empty commit.
        cycle(1, 0, 0, 0, 1, 1);
        idle(3, 1);

        // Backpressure hold.
        wr(5, 32'h55);
        wr(9, 32'h99);
        cycle(1, 0, 0, 0, 1, 0);
        idle(5, 0);
        idle(4, 1);

        // Pending sync during drain, then overrun.
        wr(2, 32'h22);
        wr(4, 32'h44);
        cycle(1, 0, 0, 0, 1, 0);
        cycle(1, 1, 0, 32'h5, 0, 0);
        cycle(1, 0, 0, 0, 1, 0);
        idle(2, 0);
        cycle(1, 0, 0, 0, 1, 0);
        idle(8, 1);

        // Write coincident with sync, out-of-range write.
        cycle(1, 1, 2, 32'h7, 1, 1);
        idle(3, 1);
        cycle(1, 1, 20, 32'hDEAD, 0, 1);
        idle(2, 1);

        // Reset mid-drain, then a sync with nothing written.
        wr(6, 32'h66);
        wr(7, 32'h77);
        cycle(1, 0, 0, 0, 1, 0);
        idle(1, 0);
        cycle(0, 0, 0, 0, 0, 1);
        idle(2, 1);
        cycle(1, 0, 0, 0, 1, 1);
        idle(3, 1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 299) != 0),
                  ($urandom_range(0, 1) == 1),
                  int'($urandom_range(0, 23)),
                  $urandom,
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 9) < 7));
        end
        idle(40, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/actor_sync_buffer.md
Name: actor_sync_buffer

Overview:
- Sits directly downstream of the CGRA top level. Consumes its actor write port (ACTOR_WR_ENABLE / ACTOR_WR_ADDR / ACTOR_DATA) and its ACTOR_SYNC_OUT strobe.
- Writes accumulate in a shadow bank. On sync, the dirty entries are committed atomically and drained one per handshake to the actor-side bus, so actors always see a coherent output set per control cycle.

Parameters:
- ACTOR_ID_WIDTH, 4, width of the actor address; equals the shared actor ID width.
- DATA_WIDTH, 32, actor data word width.
- NUM_ACTORS, 16, implemented entries; must be ≤ 2**ACTOR_ID_WIDTH.

Ports:
- CLK_I  in  1  single clock, shared with the CGRA
- RST_N_I  in  1  synchronous reset, active-low
- ACTOR_WR_ENABLE_I  in  1  write strobe from CGRA
- ACTOR_WR_ADDR_I  in  ACTOR_ID_WIDTH  target actor
- ACTOR_DATA_I  in  DATA_WIDTH  write data
- ACTOR_SYNC_OUT_I  in  1  one-cycle commit strobe from CGRA
- OUT_VALID_O  out  1  drain word valid
- OUT_READY_I  in  1  actor bus accepts word
- OUT_ADDR_O  out  ACTOR_ID_WIDTH  actor of drained word
- OUT_DATA_O  out  DATA_WIDTH  drained value
- BUSY_O  out  1  drain in progress or commit pending
- OVERRUN_O  out  1  sticky: sync lost
- ADDR_ERR_O  out  1  sticky: write to address ≥ NUM_ACTORS

Behaviour:
- Reset (RST_N_I low at a clock edge):
  - All outputs 0.
  - Shadow and active dirty masks cleared, pending flag cleared, state IDLE.
  - Data RAMs are not cleared.
  - Reset mid-drain abandons the drain with no further OUT_VALID_O.
- Shadow write:
  - Write with ACTOR_WR_ENABLE_I=1 and addr < NUM_ACTORS stores data and sets the shadow dirty bit. Last write wins.
  - Write with addr ≥ NUM_ACTORS is dropped and sets ADDR_ERR_O.
- Commit (internal event, taken when a commit is due and state is IDLE):
  - Copies shadow data to active data and shadow dirty to active mask.
  - Clears shadow dirty.
  - Goes to DRAIN if the mask is non-zero, otherwise stays IDLE.
  - A write in the same cycle as the sync strobe is included in that commit (write-then-copy).
  - A write in the same cycle as a deferred commit is also included in that commit.
- FSM IDLE:
  - ACTOR_SYNC_OUT_I=1 → commit at this edge.
- FSM DRAIN:
  - OUT_VALID_O=1. OUT_ADDR_O/OUT_DATA_O show the lowest-index set bit of the active mask.
  - Outputs are registered and stable while OUT_VALID_O && !OUT_READY_I.
  - On handshake, clear that bit and present the next set bit in the following cycle; no bubble required but one is allowed.
  - After the last handshake, OUT_VALID_O=0 and state goes to IDLE (or commits if pending).
- Sync during DRAIN:
  - Sets the pending flag (one deep). The commit is performed in the cycle the drain completes.
  - Sync while pending is already set: OVERRUN_O=1 sticky. The shadow keeps accumulating and is captured by the single pending commit.
- BUSY_O = (state==DRAIN) | pending.
- Latency: sync at edge t → OUT_VALID_O high in cycle t+1 (given at least one dirty entry). Empty commit produces no output and leaves BUSY_O low.
- Sticky flags clear only on reset.

Optional Feature:
- Macro: ACTOR_BUF_TIMESTAMP_EN.
- With the macro:
  - A 32-bit free-running cycle counter (reset 0, wraps) is added.
  - Its value is captured at every commit and driven on extra port OUT_STAMP_O [31:0], valid with every drained word of that commit.
- Without the macro: no counter and no port; the rest of the behaviour is identical.

Decomposition:
- Shared actor package (alongside the existing sensor/actor interface definitions) holds:
  - ACTOR_ID_WIDTH default and DATA_WIDTH default;
  - FSM state encoding {IDLE, DRAIN};
  - the stamp width constant.
- One sub-module is natural: actor_prio_enc, a combinational lowest-set-bit priority encoder over NUM_ACTORS bits returning index plus any-set.

Test Plan:
- Writes addr 3=0xA, addr 1=0xB, addr 3=0xC, then sync with OUT_READY_I=1 → two words in order (1,0xB), (3,0xC); BUSY_O falls after the second handshake.
- Sync with no prior writes → OUT_VALID_O stays 0, BUSY_O stays 0.
- OUT_READY_I=0 for 5 cycles during drain → addr/data held constant, no word lost or duplicated.
- Second sync during drain with new write addr 0=0x5 → first set drains fully, then (0,0x5) drains, OVERRUN_O=0. A third sync while pending → OVERRUN_O=1.
- Write addr 2=0x7 in the same cycle as sync → (2,0x7) appears in that drain. Write to addr 20 (NUM_ACTORS=16) → ignored, ADDR_ERR_O=1.
- RST_N_I low mid-drain → outputs 0 next cycle. A later sync without writes produces no words.
